// File: rtl/sort_stream_tx.sv
// Captures four W-bit elements, sorts them descending in place, streams them out largest first.
// Latency: load at edge 0, one compare-swap per edge 1..6, first beat valid after edge 6.
// Backpressure: out_data/out_last/idx hold while out_valid & !out_ready; loads only accepted in IDLE.
module sort_stream_tx #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic [W-1:0] sw76,
  input  logic [W-1:0] sw54,
  input  logic [W-1:0] sw32,
  input  logic [W-1:0] sw10,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, SORT, SEND} state_t;

  state_t              state_q, state_d;
  logic [3:0][W-1:0]   r_q, r_d;
  logic [2:0]          step_q, step_d;
  logic [1:0]          idx_q, idx_d;
  logic                out_valid_q, out_valid_d;
  logic [W-1:0]        out_data_q, out_data_d;
  logic                out_last_q, out_last_d;
  logic                load_ready_q, load_ready_d;
  logic                busy_q, busy_d;
  logic [1:0]          ci, cj;

  // Next-state: capture on load, one compare-swap per SORT cycle, step through idx in SEND.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    step_d  = step_q;
    idx_d   = idx_q;
    ci      = 2'd1;
    cj      = 2'd0;

    case (state_q)
      IDLE: begin
        if (load_valid && load_ready_q) begin
          r_d     = {sw76, sw54, sw32, sw10};
          step_d  = 3'd0;
          state_d = SORT;
        end
      end

      SORT: begin
        // Fixed compare network: the larger value migrates toward the higher index.
        case (step_q)
          3'd0:    begin ci = 2'd3; cj = 2'd2; end
          3'd1:    begin ci = 2'd3; cj = 2'd1; end
          3'd2:    begin ci = 2'd3; cj = 2'd0; end
          3'd3:    begin ci = 2'd2; cj = 2'd1; end
          3'd4:    begin ci = 2'd2; cj = 2'd0; end
          default: begin ci = 2'd1; cj = 2'd0; end
        endcase
        if (r_q[ci] < r_q[cj]) begin
          r_d[ci] = r_q[cj];
          r_d[cj] = r_q[ci];
        end
        if (step_q >= 3'd5) begin
          idx_d   = 2'd3;
          state_d = SEND;
        end else begin
          step_d = step_q + 3'd1;
        end
      end

      SEND: begin
        if (out_ready) begin
          if (idx_q == 2'd0) begin
            state_d = IDLE;
          end else begin
            idx_d = idx_q - 2'd1;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Outputs are registered views of the next state so they change cleanly on the edge.
    out_valid_d  = (state_d == SEND);
    out_data_d   = out_valid_d ? r_d[idx_d] : '0;
    out_last_d   = out_valid_d && (idx_d == 2'd0);
    load_ready_d = (state_d == IDLE);
    busy_d       = (state_d != IDLE);
  end

  // State and registered outputs; reset aborts any sort or transmission in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      r_q          <= '0;
      step_q       <= 3'd0;
      idx_q        <= 2'd3;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      load_ready_q <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      r_q          <= r_d;
      step_q       <= step_d;
      idx_q        <= idx_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      load_ready_q <= load_ready_d;
      busy_q       <= busy_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign load_ready = load_ready_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_sort_stream_tx.sv
// Bench for sort_stream_tx: table vectors, reset abort sequence, randomized loads vs a sort model.
// Loads are issued back-to-back as soon as load_ready returns.
// Outputs sampled #1 after posedge or on negedge; inputs driven with blocking assignments.
module tb_sort_stream_tx;
  localparam int W = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         load_valid;
  logic         load_ready;
  logic [W-1:0] sw76, sw54, sw32, sw10;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         busy;

  int tests = 0;
  int fails = 0;

  sort_stream_tx #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_valid(load_valid), .load_ready(load_ready),
    .sw76(sw76), .sw54(sw54), .sw32(sw32), .sw10(sw10),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][W-1:0] in;    // {sw76, sw54, sw32, sw10}
    logic [3:0][W-1:0] exp;   // exp[3] is the first beat, exp[0] the last
    int                mode;  // 0: ready high, 1: fixed toggle pattern, 2: random
    bit                glitch;
  } vec_t;

  int pat[7] = '{1, 0, 0, 1, 0, 1, 1};

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_seq(input logic [3:0][W-1:0] in, input logic [3:0][W-1:0] exp,
                        input int mode, input bit glitch);
    int n;
    int rdy;
    bit stall;
    logic [W-1:0] pd;
    logic pl;
    @(negedge clk);
    check("load_ready_idle", load_ready, 1);
    {sw76, sw54, sw32, sw10} = in;
    load_valid = 1'b1;
    @(posedge clk); #1;
    // Inputs change after the handshake; they must not influence this sort.
    load_valid = glitch;
    {sw76, sw54, sw32, sw10} = '0;
    check("busy_sort", busy, 1);
    check("load_ready_sort", load_ready, 0);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (k < 6) begin
        check("valid_low_sort", out_valid, 0);
        check("data_zero_sort", out_data, 0);
      end else begin
        check("first_valid_edge6", out_valid, 1);
      end
    end
    n = 0;
    stall = 1'b0;
    pd = '0;
    pl = 1'b0;
    for (int cyc = 0; cyc < 64 && n < 4; cyc++) begin
      @(negedge clk);
      rdy = (mode == 0) ? 1 : (mode == 1) ? pat[cyc % 7] : int'($urandom_range(0, 1));
      out_ready = rdy[0];
      check("send_valid", out_valid, 1);
      check("load_ready_send", load_ready, 0);
      if (stall) begin
        check("stall_data", out_data, pd);
        check("stall_last", out_last, pl);
      end
      if (rdy != 0) begin
        check("beat_data", out_data, exp[3-n]);
        check("beat_last", out_last, (n == 3) ? 1 : 0);
        n++;
        if (n == 4) load_valid = 1'b0;
      end
      stall = (rdy == 0);
      pd = out_data;
      pl = out_last;
    end
    check("beat_count", n, 4);
    @(posedge clk); #1;
    check("done_valid", out_valid, 0);
    check("done_data", out_data, 0);
    check("done_last", out_last, 0);
    check("done_load_ready", load_ready, 1);
    check("done_busy", busy, 0);
  endtask

  vec_t vecs[4];

  initial begin
    logic [3:0][W-1:0] rin, rexp;
    int a[4];
    int t;

    rst_n = 1'b0;
    load_valid = 1'b0;
    out_ready = 1'b0;
    {sw76, sw54, sw32, sw10} = '0;

    vecs[0] = '{in: {2'd1, 2'd3, 2'd0, 2'd2}, exp: {2'd3, 2'd2, 2'd1, 2'd0}, mode: 0, glitch: 1'b0};
    vecs[1] = '{in: {2'd2, 2'd2, 2'd2, 2'd2}, exp: {2'd2, 2'd2, 2'd2, 2'd2}, mode: 0, glitch: 1'b0};
    vecs[2] = '{in: {2'd0, 2'd1, 2'd2, 2'd3}, exp: {2'd3, 2'd2, 2'd1, 2'd0}, mode: 1, glitch: 1'b0};
    vecs[3] = '{in: {2'd3, 2'd0, 2'd3, 2'd1}, exp: {2'd3, 2'd3, 2'd1, 2'd0}, mode: 0, glitch: 1'b1};

    #12;
    check("rst_load_ready", load_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table vectors, issued back-to-back.
    for (int v = 0; v < 4; v++) begin
      do_seq(vecs[v].in, vecs[v].exp, vecs[v].mode, vecs[v].glitch);
    end

    // Reset asserted mid-SEND after two beats have left.
    @(negedge clk);
    {sw76, sw54, sw32, sw10} = {2'd0, 2'd1, 2'd2, 2'd3};
    load_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("pre_reset_valid", out_valid, 1);
    check("pre_reset_data", out_data, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_last", out_last, 0);
    check("arst_data", out_data, 0);
    check("arst_load_ready", load_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_idle_valid", out_valid, 0);
    do_seq({2'd1, 2'd0, 2'd1, 2'd0}, {2'd1, 2'd1, 2'd0, 2'd0}, 0, 1'b0);

    // Randomized loads and backpressure against a descending-sort model.
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < 4; i++) begin
        a[i] = int'($urandom_range(0, (1 << W) - 1));
        rin[i] = a[i][W-1:0];
      end
      for (int i = 0; i < 3; i++) begin
        for (int j = i + 1; j < 4; j++) begin
          if (a[j] > a[i]) begin
            t = a[i];
            a[i] = a[j];
            a[j] = t;
          end
        end
      end
      for (int i = 0; i < 4; i++) rexp[3-i] = a[i][W-1:0];
      do_seq(rin, rexp, 2, it[0]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
